// File: rtl/rob_commit_pkg.sv
// rtl/rob_commit_pkg.sv - shared constants and entry layout for the reorder buffer
// Contents: RRF_SEL (tag width), RRF_NUM (entry count), REG_SEL (logical register
// width) and rob_entry_t, the per-entry record held in the reorder buffer.
package rob_commit_pkg;

    localparam int RRF_SEL = 6;
    localparam int RRF_NUM = 64;
    localparam int REG_SEL = 5;

    typedef struct packed {
        logic               valid;
        logic               finished;
        logic               dst_en;
        logic [REG_SEL-1:0] dst_num;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rtl/rob_ptr_ctrl.sv - head/tail/occupancy bookkeeping for the reorder buffer
// Ports:
//   clk_i, reset_i (async active-high), flush_i (sync clear)
//   alloc_i       entry allocated at tail this edge
//   commit_i      head entry retires this edge
//   head_o/tail_o current pointers
//   ready_o       not full
//   free_count_o  RRF_NUM - occupancy
module rob_ptr_ctrl
    import rob_commit_pkg::*;
#(
    parameter int P_RRF_SEL = RRF_SEL,
    parameter int P_RRF_NUM = RRF_NUM
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 alloc_i,
    input  logic                 commit_i,
    output logic [P_RRF_SEL-1:0] head_o,
    output logic [P_RRF_SEL-1:0] tail_o,
    output logic                 ready_o,
    output logic [P_RRF_SEL:0]   free_count_o
);

    localparam logic [P_RRF_SEL:0] FULL_CNT = (P_RRF_SEL+1)'(P_RRF_NUM);

    logic [P_RRF_SEL-1:0] head_q, head_d;
    logic [P_RRF_SEL-1:0] tail_q, tail_d;
    logic [P_RRF_SEL:0]   count_q, count_d;

    // Pointers wrap naturally because RRF_NUM is a power of two.
    always_comb begin
        head_d  = head_q + P_RRF_SEL'(commit_i);
        tail_d  = tail_q + P_RRF_SEL'(alloc_i);
        count_d = count_q + (P_RRF_SEL+1)'(alloc_i) - (P_RRF_SEL+1)'(commit_i);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o       = head_q;
    assign tail_o       = tail_q;
    // Full test uses the registered count only, so a same-cycle commit never
    // opens a slot for the request presented in that cycle.
    assign ready_o      = (count_q != FULL_CNT);
    assign free_count_o = FULL_CNT - count_q;

endmodule

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order reorder buffer and commit sequencer
// Optional feature: define ROB_COMMIT_CNT_EN to add commit_cnt_o (64-bit retire count).
// Ports:
//   clk_i, reset_i (async active-high), flush_i (sync empty)
//   dp_*      dispatch request, ready and allocated tag
//   cpl1_*, cpl2_*  completion ports (tag marks entry finished)
//   commit_valid_o, completed_*  head retirement towards ARF / rename table
//   free_count_o  number of empty entries
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               dp_valid_i,
    input  logic               dp_dst_en_i,
    input  logic [REG_SEL-1:0] dp_dst_num_i,
    output logic               dp_ready_o,
    output logic [RRF_SEL-1:0] dp_rrftag_o,
    input  logic               cpl1_valid_i,
    input  logic [RRF_SEL-1:0] cpl1_rrftag_i,
    input  logic               cpl2_valid_i,
    input  logic [RRF_SEL-1:0] cpl2_rrftag_i,
    output logic               commit_valid_o,
    output logic               completed_we_o,
    output logic [REG_SEL-1:0] completed_dst_num_o,
    output logic [RRF_SEL-1:0] completed_dst_rrftag_o,
`ifdef ROB_COMMIT_CNT_EN
    output logic [63:0]        commit_cnt_o,
`endif
    output logic [RRF_SEL:0]   free_count_o
);

    rob_entry_t         ent_q [RRF_NUM];
    rob_entry_t         head_ent;
    logic [RRF_SEL-1:0] head;
    logic [RRF_SEL-1:0] tail;
    logic               alloc;
    logic               commit;

    rob_ptr_ctrl u_ptr (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .alloc_i      (alloc),
        .commit_i     (commit),
        .head_o       (head),
        .tail_o       (tail),
        .ready_o      (dp_ready_o),
        .free_count_o (free_count_o)
    );

    assign alloc       = dp_valid_i && dp_ready_o;
    assign dp_rrftag_o = tail;

    // Commit decode looks only at registered entry state.
    assign head_ent = ent_q[head];
    assign commit   = head_ent.valid && head_ent.finished;

    assign commit_valid_o         = commit;
    assign completed_we_o         = commit && head_ent.dst_en;
    assign completed_dst_num_o    = commit ? head_ent.dst_num : '0;
    assign completed_dst_rrftag_o = commit ? head : '0;

    // Update order matters: completions first (gated by current valid), then
    // the commit clear, then allocation. Allocation can never target the head
    // while it commits, since that would need an empty and committing buffer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < RRF_NUM; i++) begin
                ent_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < RRF_NUM; i++) begin
                ent_q[i].valid    <= 1'b0;
                ent_q[i].finished <= 1'b0;
            end
        end else begin
            if (cpl1_valid_i && ent_q[cpl1_rrftag_i].valid) begin
                ent_q[cpl1_rrftag_i].finished <= 1'b1;
            end
            if (cpl2_valid_i && ent_q[cpl2_rrftag_i].valid) begin
                ent_q[cpl2_rrftag_i].finished <= 1'b1;
            end
            if (commit) begin
                ent_q[head].valid    <= 1'b0;
                ent_q[head].finished <= 1'b0;
            end
            if (alloc) begin
                ent_q[tail].valid    <= 1'b1;
                ent_q[tail].finished <= 1'b0;
                ent_q[tail].dst_en   <= dp_dst_en_i;
                ent_q[tail].dst_num  <= dp_dst_num_i;
            end
        end
    end

`ifdef ROB_COMMIT_CNT_EN
    logic [63:0] commit_cnt_q;

    // Survives flush; a commit discarded by flush is not counted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            commit_cnt_q <= '0;
        end else if (commit && !flush_i) begin
            commit_cnt_q <= commit_cnt_q + 64'd1;
        end
    end

    assign commit_cnt_o = commit_cnt_q;
`endif

endmodule
